// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares the single combinational data-memory read port between the scalar
// load path and the vector load path of the MEM stage. One requester wins per
// access; its address and access kind are latched and driven to the memory for
// one cycle (ACCESS), the returned data is registered at the end of that
// cycle, and the winner sees a one-cycle rvalid pulse in the following cycle
// (RESP). Requests still pending in RESP start the next access back-to-back,
// so the port sustains one access every two cycles.
//
// Ports:
//   clk_i           clock
//   rst_i           synchronous active-high reset
//   s_req_i         scalar read request (level)
//   s_addr_i        scalar read address
//   s_gnt_o         scalar request accepted, one-cycle pulse (ACCESS)
//   s_rvalid_o      scalar read data valid, one-cycle pulse (RESP)
//   s_rdata_o       scalar read data, mem_rd[SW-1:0], held until next capture
//   v_req_i         vector read request (level)
//   v_addr_i        vector read address
//   v_gnt_o         vector request accepted, one-cycle pulse (ACCESS)
//   v_rvalid_o      vector read data valid, one-cycle pulse (RESP)
//   v_rdata_o       vector read data, full mem_rd, held until next capture
//   mem_isVector_o  memory read mode: 1 = vector, 0 = scalar
//   mem_address_o   memory read address (passed through unmodified)
//   mem_rd_i        memory read data, combinational from mode/address
//   busy_o          an access is in progress (state is not IDLE)
//
// Parameters:
//   AW  address width
//   VW  vector read data width (memory read data width)
//   SW  scalar read data width
//   RR  1 = round-robin on simultaneous requests, 0 = fixed scalar priority
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int AW = 32,
  parameter int VW = 192,
  parameter int SW = 32,
  parameter bit RR = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,

  input  logic          s_req_i,
  input  logic [AW-1:0] s_addr_i,
  output logic          s_gnt_o,
  output logic          s_rvalid_o,
  output logic [SW-1:0] s_rdata_o,

  input  logic          v_req_i,
  input  logic [AW-1:0] v_addr_i,
  output logic          v_gnt_o,
  output logic          v_rvalid_o,
  output logic [VW-1:0] v_rdata_o,

  output logic          mem_isVector_o,
  output logic [AW-1:0] mem_address_o,
  input  logic [VW-1:0] mem_rd_i,

  output logic          busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e        state_q,       state_d;
  logic          lastGrantVec_q, lastGrantVec_d;
  logic          kind_q,        kind_d;
  logic [AW-1:0] addr_q,        addr_d;
  logic          sGnt_q,        sGnt_d;
  logic          vGnt_q,        vGnt_d;
  logic          sRvalid_q,     sRvalid_d;
  logic          vRvalid_q,     vRvalid_d;
  logic [SW-1:0] sRdata_q,      sRdata_d;
  logic [VW-1:0] vRdata_q,      vRdata_d;

  logic          anyReq;
  logic          pickVec;

  // Winner selection. A lone requester always wins. On a tie, round-robin
  // hands the port to whoever did not get the previous grant; fixed priority
  // always favours the scalar path.
  always_comb begin
    anyReq  = s_req_i | v_req_i;
    pickVec = 1'b0;
    if (v_req_i && !s_req_i) begin
      pickVec = 1'b1;
    end else if (v_req_i && s_req_i) begin
      pickVec = RR ? ~lastGrantVec_q : 1'b0;
    end
  end

  // Next-state and output-register logic. Pulses (gnt, rvalid) default low so
  // they last exactly one cycle; everything else holds unless updated.
  // Requests are only looked at in IDLE and RESP, so anything that changes
  // on the request side during ACCESS has no effect on the access in flight.
  always_comb begin
    state_d        = state_q;
    lastGrantVec_d = lastGrantVec_q;
    kind_d         = kind_q;
    addr_d         = addr_q;
    sGnt_d         = 1'b0;
    vGnt_d         = 1'b0;
    sRvalid_d      = 1'b0;
    vRvalid_d      = 1'b0;
    sRdata_d       = sRdata_q;
    vRdata_d       = vRdata_q;

    unique case (state_q)
      IDLE, RESP: begin
        if (anyReq) begin
          state_d        = ACCESS;
          kind_d         = pickVec;
          addr_d         = pickVec ? v_addr_i : s_addr_i;
          lastGrantVec_d = pickVec;
          sGnt_d         = ~pickVec;
          vGnt_d         = pickVec;
        end else begin
          state_d = IDLE;
        end
      end

      ACCESS: begin
        // The memory port has been driven from the latched request for the
        // whole cycle, so its data is stable and captured at this edge.
        if (kind_q) begin
          vRdata_d  = mem_rd_i;
          vRvalid_d = 1'b1;
        end else begin
          sRdata_d  = mem_rd_i[SW-1:0];
          sRvalid_d = 1'b1;
        end
        state_d = RESP;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset drops any access in flight: no rvalid
  // is produced and every output returns to zero. The last grant resets to
  // vector so the scalar path wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      lastGrantVec_q <= 1'b1;
      kind_q         <= 1'b0;
      addr_q         <= '0;
      sGnt_q         <= 1'b0;
      vGnt_q         <= 1'b0;
      sRvalid_q      <= 1'b0;
      vRvalid_q      <= 1'b0;
      sRdata_q       <= '0;
      vRdata_q       <= '0;
    end else begin
      state_q        <= state_d;
      lastGrantVec_q <= lastGrantVec_d;
      kind_q         <= kind_d;
      addr_q         <= addr_d;
      sGnt_q         <= sGnt_d;
      vGnt_q         <= vGnt_d;
      sRvalid_q      <= sRvalid_d;
      vRvalid_q      <= vRvalid_d;
      sRdata_q       <= sRdata_d;
      vRdata_q       <= vRdata_d;
    end
  end

  // Every output comes straight from a register, so the memory port and the
  // requesters never see combinational paths through the arbiter.
  assign s_gnt_o        = sGnt_q;
  assign v_gnt_o        = vGnt_q;
  assign s_rvalid_o     = sRvalid_q;
  assign v_rvalid_o     = vRvalid_q;
  assign s_rdata_o      = sRdata_q;
  assign v_rdata_o      = vRdata_q;
  assign mem_isVector_o = kind_q;
  assign mem_address_o  = addr_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Two arbiter instances share one clock: dutA uses round-robin arbitration,
// dutB uses fixed scalar priority. Each has its own combinational memory
// model. Each row of a table gives the inputs driven before a rising edge and
// the outputs expected just after that edge.
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  localparam int AW = 32;
  localparam int VW = 192;
  localparam int SW = 32;

  typedef struct {
    logic          rst;
    logic          sReq;
    logic [AW-1:0] sAddr;
    logic          vReq;
    logic [AW-1:0] vAddr;
    logic          sGnt;
    logic          vGnt;
    logic          sRvalid;
    logic          vRvalid;
    logic          busy;
    logic          memIsVec;
    logic [AW-1:0] memAddr;
    logic [SW-1:0] sRdata;
    logic [VW-1:0] vRdata;
  } vec_t;

  logic clk = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Clock generation
  always #5 clk = ~clk;

  // Memory model: scalar reads return a recognisable low word (DEADBEEF at
  // address 4) with filler above it; vector reads return six address-derived
  // words, so the two modes and different addresses never alias.
  function automatic logic [VW-1:0] memModel(input logic isVec, input logic [AW-1:0] addr);
    logic [31:0] lo;
    if (isVec) begin
      return {addr ^ 32'h1111_1111, addr ^ 32'h2222_2222, addr ^ 32'h3333_3333,
              addr ^ 32'h4444_4444, addr ^ 32'h5555_5555, addr ^ 32'h6666_6666};
    end
    lo = (addr == 32'h4) ? 32'hDEAD_BEEF : (addr ^ 32'h5A5A_0000);
    return {{5{32'hCAFE_0000 | addr}}, lo};
  endfunction

  function automatic logic [SW-1:0] sD(input logic [AW-1:0] addr);
    logic [VW-1:0] full;
    full = memModel(1'b0, addr);
    return full[SW-1:0];
  endfunction

  function automatic logic [VW-1:0] vD(input logic [AW-1:0] addr);
    return memModel(1'b1, addr);
  endfunction

  // dutA signals (round-robin)
  logic          aRst, aSReq, aVReq;
  logic [AW-1:0] aSAddr, aVAddr;
  logic          aSGnt, aVGnt, aSRvalid, aVRvalid, aBusy, aMemIsVec;
  logic [SW-1:0] aSRdata;
  logic [VW-1:0] aVRdata, aMemRd;
  logic [AW-1:0] aMemAddr;

  // dutB signals (fixed priority)
  logic          bRst, bSReq, bVReq;
  logic [AW-1:0] bSAddr, bVAddr;
  logic          bSGnt, bVGnt, bSRvalid, bVRvalid, bBusy, bMemIsVec;
  logic [SW-1:0] bSRdata;
  logic [VW-1:0] bVRdata, bMemRd;
  logic [AW-1:0] bMemAddr;

  assign aMemRd = memModel(aMemIsVec, aMemAddr);
  assign bMemRd = memModel(bMemIsVec, bMemAddr);

  dmem_port_arbiter #(.AW(AW), .VW(VW), .SW(SW), .RR(1'b1)) dutA (
    .clk_i(clk), .rst_i(aRst),
    .s_req_i(aSReq), .s_addr_i(aSAddr), .s_gnt_o(aSGnt),
    .s_rvalid_o(aSRvalid), .s_rdata_o(aSRdata),
    .v_req_i(aVReq), .v_addr_i(aVAddr), .v_gnt_o(aVGnt),
    .v_rvalid_o(aVRvalid), .v_rdata_o(aVRdata),
    .mem_isVector_o(aMemIsVec), .mem_address_o(aMemAddr), .mem_rd_i(aMemRd),
    .busy_o(aBusy)
  );

  dmem_port_arbiter #(.AW(AW), .VW(VW), .SW(SW), .RR(1'b0)) dutB (
    .clk_i(clk), .rst_i(bRst),
    .s_req_i(bSReq), .s_addr_i(bSAddr), .s_gnt_o(bSGnt),
    .s_rvalid_o(bSRvalid), .s_rdata_o(bSRdata),
    .v_req_i(bVReq), .v_addr_i(bVAddr), .v_gnt_o(bVGnt),
    .v_rvalid_o(bVRvalid), .v_rdata_o(bVRdata),
    .mem_isVector_o(bMemIsVec), .mem_address_o(bMemAddr), .mem_rd_i(bMemRd),
    .busy_o(bBusy)
  );

  function automatic vec_t mkRow(
    input logic rst, input logic sReq, input logic [AW-1:0] sAddr,
    input logic vReq, input logic [AW-1:0] vAddr,
    input logic sGnt, input logic vGnt, input logic sRvalid, input logic vRvalid,
    input logic busy, input logic memIsVec, input logic [AW-1:0] memAddr,
    input logic [SW-1:0] sRdata, input logic [VW-1:0] vRdata);
    vec_t r;
    r.rst = rst; r.sReq = sReq; r.sAddr = sAddr; r.vReq = vReq; r.vAddr = vAddr;
    r.sGnt = sGnt; r.vGnt = vGnt; r.sRvalid = sRvalid; r.vRvalid = vRvalid;
    r.busy = busy; r.memIsVec = memIsVec; r.memAddr = memAddr;
    r.sRdata = sRdata; r.vRdata = vRdata;
    return r;
  endfunction

  // Drive one row's inputs into the selected instance, then let one edge pass
  // and settle before the outputs are looked at.
  task automatic applyStimulus(input vec_t r, input bit toB);
    if (toB) begin
      bRst = r.rst; bSReq = r.sReq; bSAddr = r.sAddr; bVReq = r.vReq; bVAddr = r.vAddr;
    end else begin
      aRst = r.rst; aSReq = r.sReq; aSAddr = r.sAddr; aVReq = r.vReq; aVAddr = r.vAddr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkField(input string tag, input string name,
                            input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s %s got %h expected %h", tag, name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input vec_t r, input bit fromB);
    if (fromB) begin
      checkField(tag, "s_gnt",        VW'(bSGnt),     VW'(r.sGnt));
      checkField(tag, "v_gnt",        VW'(bVGnt),     VW'(r.vGnt));
      checkField(tag, "s_rvalid",     VW'(bSRvalid),  VW'(r.sRvalid));
      checkField(tag, "v_rvalid",     VW'(bVRvalid),  VW'(r.vRvalid));
      checkField(tag, "busy",         VW'(bBusy),     VW'(r.busy));
      checkField(tag, "mem_isVector", VW'(bMemIsVec), VW'(r.memIsVec));
      checkField(tag, "mem_address",  VW'(bMemAddr),  VW'(r.memAddr));
      checkField(tag, "s_rdata",      VW'(bSRdata),   VW'(r.sRdata));
      checkField(tag, "v_rdata",      bVRdata,        r.vRdata);
    end else begin
      checkField(tag, "s_gnt",        VW'(aSGnt),     VW'(r.sGnt));
      checkField(tag, "v_gnt",        VW'(aVGnt),     VW'(r.vGnt));
      checkField(tag, "s_rvalid",     VW'(aSRvalid),  VW'(r.sRvalid));
      checkField(tag, "v_rvalid",     VW'(aVRvalid),  VW'(r.vRvalid));
      checkField(tag, "busy",         VW'(aBusy),     VW'(r.busy));
      checkField(tag, "mem_isVector", VW'(aMemIsVec), VW'(r.memIsVec));
      checkField(tag, "mem_address",  VW'(aMemAddr),  VW'(r.memAddr));
      checkField(tag, "s_rdata",      VW'(aSRdata),   VW'(r.sRdata));
      checkField(tag, "v_rdata",      aVRdata,        r.vRdata);
    end
  endtask

  // Main test: round-robin table on dutA, then the fixed-priority sequence on
  // dutB, then the summary.
  initial begin
    vec_t tabA[$];
    vec_t r;
    logic [SW-1:0] beef;
    logic [SW-1:0] s10, s08, s60;
    logic [VW-1:0] v02, v20, v30, v50, v70;

    beef = 32'hDEAD_BEEF;
    s10 = sD(32'h10); s08 = sD(32'h8); s60 = sD(32'h60);
    v02 = vD(32'h2); v20 = vD(32'h20); v30 = vD(32'h30);
    v50 = vD(32'h50); v70 = vD(32'h70);

    aRst = 1'b1; aSReq = 1'b0; aSAddr = '0; aVReq = 1'b0; aVAddr = '0;
    bRst = 1'b1; bSReq = 1'b0; bSAddr = '0; bVReq = 1'b0; bVAddr = '0;

    //                 rst sReq sAddr  vReq vAddr  sG vG sR vR bsy iV memAddr sRdata vRdata
    // reset state
    tabA.push_back(mkRow(1, 0, 32'h0,  0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  '0,   '0));
    // single scalar request at address 4
    tabA.push_back(mkRow(0, 1, 32'h4,  0, 32'h0,  1, 0, 0, 0, 1, 0, 32'h4,  '0,   '0));
    tabA.push_back(mkRow(0, 0, 32'h4,  0, 32'h0,  0, 0, 1, 0, 1, 0, 32'h4,  beef, '0));
    tabA.push_back(mkRow(0, 0, 32'h0,  0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h4,  beef, '0));
    // single vector request at address 2
    tabA.push_back(mkRow(0, 0, 32'h0,  1, 32'h2,  0, 1, 0, 0, 1, 1, 32'h2,  beef, '0));
    tabA.push_back(mkRow(0, 0, 32'h0,  0, 32'h2,  0, 0, 0, 1, 1, 1, 32'h2,  beef, v02));
    tabA.push_back(mkRow(0, 0, 32'h0,  0, 32'h0,  0, 0, 0, 0, 0, 1, 32'h2,  beef, v02));
    // reset, then both held: S, V, S, V back-to-back
    tabA.push_back(mkRow(1, 0, 32'h0,  0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  '0,   '0));
    tabA.push_back(mkRow(0, 1, 32'h10, 1, 32'h20, 1, 0, 0, 0, 1, 0, 32'h10, '0,   '0));
    tabA.push_back(mkRow(0, 1, 32'h10, 1, 32'h20, 0, 0, 1, 0, 1, 0, 32'h10, s10,  '0));
    tabA.push_back(mkRow(0, 1, 32'h10, 1, 32'h20, 0, 1, 0, 0, 1, 1, 32'h20, s10,  '0));
    tabA.push_back(mkRow(0, 1, 32'h10, 1, 32'h20, 0, 0, 0, 1, 1, 1, 32'h20, s10,  v20));
    tabA.push_back(mkRow(0, 1, 32'h10, 1, 32'h20, 1, 0, 0, 0, 1, 0, 32'h10, s10,  v20));
    tabA.push_back(mkRow(0, 1, 32'h10, 1, 32'h20, 0, 0, 1, 0, 1, 0, 32'h10, s10,  v20));
    tabA.push_back(mkRow(0, 1, 32'h10, 1, 32'h20, 0, 1, 0, 0, 1, 1, 32'h20, s10,  v20));
    tabA.push_back(mkRow(0, 0, 32'h10, 0, 32'h20, 0, 0, 0, 1, 1, 1, 32'h20, s10,  v20));
    tabA.push_back(mkRow(0, 0, 32'h0,  0, 32'h0,  0, 0, 0, 0, 0, 1, 32'h20, s10,  v20));
    // vector address changed while ACCESS is in progress
    tabA.push_back(mkRow(0, 0, 32'h0,  1, 32'h30, 0, 1, 0, 0, 1, 1, 32'h30, s10,  v20));
    tabA.push_back(mkRow(0, 0, 32'h0,  1, 32'h99, 0, 0, 0, 1, 1, 1, 32'h30, s10,  v30));
    tabA.push_back(mkRow(0, 0, 32'h0,  0, 32'h0,  0, 0, 0, 0, 0, 1, 32'h30, s10,  v30));
    // reset during a vector ACCESS, then a normal scalar access
    tabA.push_back(mkRow(0, 0, 32'h0,  1, 32'h40, 0, 1, 0, 0, 1, 1, 32'h40, s10,  v30));
    tabA.push_back(mkRow(1, 0, 32'h0,  0, 32'h40, 0, 0, 0, 0, 0, 0, 32'h0,  '0,   '0));
    tabA.push_back(mkRow(0, 1, 32'h8,  0, 32'h0,  1, 0, 0, 0, 1, 0, 32'h8,  '0,   '0));
    tabA.push_back(mkRow(0, 0, 32'h0,  0, 32'h0,  0, 0, 1, 0, 1, 0, 32'h8,  s08,  '0));
    tabA.push_back(mkRow(0, 0, 32'h0,  0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h8,  s08,  '0));
    // reset during RESP clears the pending pulse and all outputs
    tabA.push_back(mkRow(0, 0, 32'h0,  1, 32'h50, 0, 1, 0, 0, 1, 1, 32'h50, s08,  '0));
    tabA.push_back(mkRow(0, 0, 32'h0,  0, 32'h0,  0, 0, 0, 1, 1, 1, 32'h50, s08,  v50));
    tabA.push_back(mkRow(1, 0, 32'h0,  0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  '0,   '0));
    tabA.push_back(mkRow(0, 0, 32'h0,  0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  '0,   '0));

    foreach (tabA[i]) begin
      applyStimulus(tabA[i], 1'b0);
      checkOutput($sformatf("rr_row%0d", i), tabA[i], 1'b0);
    end

    // Fixed priority: scalar keeps winning while it holds its request; the
    // vector path gets the port in the RESP cycle after scalar lets go.
    r = mkRow(1, 0, 32'h0,  0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  '0,  '0);
    applyStimulus(r, 1'b1); checkOutput("fp_reset", r, 1'b1);
    r = mkRow(0, 1, 32'h60, 1, 32'h70, 1, 0, 0, 0, 1, 0, 32'h60, '0,  '0);
    applyStimulus(r, 1'b1); checkOutput("fp_gnt_s1", r, 1'b1);
    r = mkRow(0, 1, 32'h60, 1, 32'h70, 0, 0, 1, 0, 1, 0, 32'h60, s60, '0);
    applyStimulus(r, 1'b1); checkOutput("fp_resp_s1", r, 1'b1);
    r = mkRow(0, 1, 32'h60, 1, 32'h70, 1, 0, 0, 0, 1, 0, 32'h60, s60, '0);
    applyStimulus(r, 1'b1); checkOutput("fp_gnt_s2", r, 1'b1);
    r = mkRow(0, 1, 32'h60, 1, 32'h70, 0, 0, 1, 0, 1, 0, 32'h60, s60, '0);
    applyStimulus(r, 1'b1); checkOutput("fp_resp_s2", r, 1'b1);
    r = mkRow(0, 0, 32'h60, 1, 32'h70, 0, 1, 0, 0, 1, 1, 32'h70, s60, '0);
    applyStimulus(r, 1'b1); checkOutput("fp_gnt_v", r, 1'b1);
    r = mkRow(0, 0, 32'h0,  0, 32'h70, 0, 0, 0, 1, 1, 1, 32'h70, s60, v70);
    applyStimulus(r, 1'b1); checkOutput("fp_resp_v", r, 1'b1);
    r = mkRow(0, 0, 32'h0,  0, 32'h0,  0, 0, 0, 0, 0, 1, 32'h70, s60, v70);
    applyStimulus(r, 1'b1); checkOutput("fp_idle", r, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory read port between the scalar load path and the vector load path.
- The memory port is combinational: isVector, address[31:0] in, rd[191:0] out.
- Arbitrates between the two requesters, drives the memory port with the winning request and registers the returned data.
- Returns data to the winner with a one-cycle valid pulse.
- Sits between the MEM stage of both pipelines and the data memory.

Parameters:
AW, 32, address width
VW, 192, vector read data width (memory rd width)
SW, 32, scalar read data width; scalar data = rd[SW-1:0]
RR, 1, 1 = round-robin on simultaneous requests; 0 = fixed scalar priority

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
s_req  input  1  scalar read request, level
s_addr  input  AW  scalar read address
s_gnt  output  1  scalar request accepted, one-cycle pulse
s_rvalid  output  1  scalar read data valid, one-cycle pulse
s_rdata  output  SW  scalar read data
v_req  input  1  vector read request, level
v_addr  input  AW  vector read address
v_gnt  output  1  vector request accepted, one-cycle pulse
v_rvalid  output  1  vector read data valid, one-cycle pulse
v_rdata  output  VW  vector read data
mem_isVector  output  1  memory read mode: 1 = vector, 0 = scalar
mem_address  output  AW  memory read address
mem_rd  input  VW  memory read data, combinational from mem_isVector/mem_address
busy  output  1  access in progress (state != IDLE)

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset state: state=IDLE; all outputs 0, including gnt, rvalid, rdata, mem_isVector, mem_address and busy. last_grant=vector, so scalar wins the first tie.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, pick a winner, latch its address and kind (vector=1, scalar=0), set winner gnt<=1, go to ACCESS.
  - Otherwise stay in IDLE.
- Winner selection:
  - Only one req high: that requester wins.
  - Both high, RR=1: the requester not in last_grant wins; last_grant updates on every grant.
  - Both high, RR=0: scalar always wins.
- ACCESS (1 cycle):
  - gnt of winner =1; the other gnt =0.
  - mem_address = latched address; mem_isVector = latched kind.
  - At the clock edge, mem_rd is captured into the winner's rdata register; winner rvalid<=1; gnt<=0; go to RESP.
  - s_rdata gets mem_rd[SW-1:0]; v_rdata gets the full mem_rd.
- RESP (1 cycle):
  - Winner rvalid=1 with valid rdata; mem_address and mem_isVector keep the last values.
  - req is re-evaluated exactly as in IDLE. If any req is high, go to ACCESS with a new grant (back-to-back); else go to IDLE.
  - rvalid is 0 in the next cycle either way.
- rdata holds its value until the next capture for that port. rvalid and gnt are never high on both ports in the same cycle.
- Requester protocol:
  - After seeing gnt high, a requester deasserts req at the following edge unless it wants another access.
  - req is sampled only in IDLE and RESP; req or addr changes during ACCESS are ignored.
  - A req still high in RESP is treated as a new request.
- Timing:
  - Latency: req sampled in cycle N → gnt in cycle N+1 → rvalid in cycle N+2.
  - Peak throughput: one access per 2 cycles.
- Fairness: with both req held continuously and RR=1, grants alternate S, V, S, V…
- Reset mid-operation (in ACCESS or RESP): the access is dropped; no rvalid is produced; state returns to IDLE; outputs take their reset values in the next cycle.
- Address is passed to memory unmodified (no alignment or range check).

Test Plan:
- Single scalar request: s_req=1, s_addr=0x4; bench mem model returns rd=0x…_DEADBEEF when mem_isVector=0 → s_gnt at N+1 with mem_address=0x4 and mem_isVector=0; s_rvalid at N+2 with s_rdata=0xDEADBEEF; v_* stay 0.
- Single vector request: v_req=1, v_addr=0x2; model returns a 192-bit pattern P → v_gnt at N+1 with mem_isVector=1; v_rvalid at N+2 with v_rdata=P.
- Simultaneous requests, RR=1, both held 8 cycles from reset → grant order S, V, S, V; four rvalid pulses at cycles 2, 4, 6, 8 after first sample; each rdata matches its own address.
- Simultaneous requests, RR=0, both held → only scalar granted while s_req stays high; vector granted in the RESP cycle after s_req drops.
- Reset asserted during ACCESS of a vector read → no v_rvalid; busy=0, mem_address=0, mem_isVector=0 the next cycle; a new s_req after reset is served with normal 2-cycle latency.
- Request changes during ACCESS: v_addr changed mid-ACCESS → mem_address keeps the latched value; the returned data corresponds to the original address.
